// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - shared types and alignment helper for the data-memory responder
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        SIZE_B    = 2'b00,
        SIZE_H    = 2'b01,
        SIZE_W    = 2'b10,
        SIZE_RSVD = 2'b11
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } dmem_state_t;

    // Reserved size is rejected separately so this only covers natural alignment.
    function automatic logic misaligned(input mem_size_t size, input logic [1:0] lsb);
        case (size)
            SIZE_H:  misaligned = lsb[0];
            SIZE_W:  misaligned = |lsb;
            default: misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane enables, store replication and load extraction/extension
module dmem_lane_align
    import riscv_mem_pkg::*;
(
    input  mem_size_t   size,
    input  logic        zext,
    input  logic [1:0]  lsb,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wrep,
    output logic [31:0] rdata
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        be    = 4'b0000;
        wrep  = wdata;
        rdata = rword;
        rbyte = rword[8*lsb +: 8];
        rhalf = lsb[1] ? rword[31:16] : rword[15:0];
        case (size)
            SIZE_B: begin
                be    = 4'b0001 << lsb;
                wrep  = {4{wdata[7:0]}};
                rdata = {{24{rbyte[7] & ~zext}}, rbyte};
            end
            SIZE_H: begin
                be    = lsb[1] ? 4'b1100 : 4'b0011;
                wrep  = {2{wdata[15:0]}};
                rdata = {{16{rhalf[15] & ~zext}}, rhalf};
            end
            SIZE_W: begin
                be    = 4'b1111;
            end
            default: begin
                be    = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - RV32I data-memory responder with wait states and owned word RAM
module dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  WAIT_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
    localparam logic [31:0] DEPTH_L   = 32'(DEPTH_WORDS);
    localparam logic        NO_WAIT   = (WAIT_STATES == 0);

    logic [31:0] mem [DEPTH_WORDS];

    dmem_state_t state;
    logic [3:0]  cnt;
    logic        we_q;
    mem_size_t   size_q;
    logic        zext_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        take;
    logic        commit;
    logic        c_we;
    mem_size_t   c_size;
    logic        c_zext;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic        c_err;
    logic [AW-1:0] idx;
    logic [31:0] rword;
    logic [3:0]  be;
    logic [31:0] wrep;
    logic [31:0] ld_data;

    assign take = req_valid && req_ready;

    // With zero wait states the commit happens on the accept edge, so use live request fields.
    always_comb begin
        if (state == IDLE) begin
            c_we    = req_we;
            c_size  = mem_size_t'(req_size);
            c_zext  = req_unsigned;
            c_addr  = req_addr;
            c_wdata = req_wdata;
        end else begin
            c_we    = we_q;
            c_size  = size_q;
            c_zext  = zext_q;
            c_addr  = addr_q;
            c_wdata = wdata_q;
        end
    end

    assign commit = (take && NO_WAIT) || (state == WAIT && cnt == 4'd0);
    assign c_err  = (c_size == SIZE_RSVD) || misaligned(c_size, c_addr[1:0])
                    || ({2'b00, c_addr[31:2]} >= DEPTH_L);
    assign idx    = c_addr[AW+1:2];
    assign rword  = mem[idx];

    dmem_lane_align u_align (
        .size  (c_size),
        .zext  (c_zext),
        .lsb   (c_addr[1:0]),
        .wdata (c_wdata),
        .rword (rword),
        .be    (be),
        .wrep  (wrep),
        .rdata (ld_data)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        we_q      <= req_we;
                        size_q    <= mem_size_t'(req_size);
                        zext_q    <= req_unsigned;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        cnt       <= WAIT_INIT;
                        req_ready <= 1'b0;
                        state     <= commit ? RESP : WAIT;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    if (commit) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            if (commit) begin
                rsp_valid <= 1'b1;
                rsp_err   <= c_err;
                rsp_rdata <= (c_err || c_we) ? 32'd0 : ld_data;
            end
        end
    end

    // RAM is never cleared; a reset landing on the commit cycle suppresses the write.
    always_ff @(posedge clk) begin
        if (reset && commit && !c_err && c_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wrep[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset1 = 1'b0;
    logic        reset3 = 1'b0;
    logic        req_valid1 = 1'b0;
    logic        req_valid3 = 1'b0;
    logic        rsp_ready1 = 1'b0;
    logic        rsp_ready3 = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b10;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;

    logic        req_ready1, rsp_valid1, rsp_err1;
    logic [31:0] rsp_rdata1;
    logic        req_ready3, rsp_valid3, rsp_err3;
    logic [31:0] rsp_rdata3;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) dut1 (
        .clk(clk), .reset(reset1),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
        .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
    );

    dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(3)) dut3 (
        .clk(clk), .reset(reset3),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3)
    );

    // One full transaction; lat counts edges from acceptance until rsp_valid is seen.
    task automatic do_txn(input bit s3, input bit we, input logic [1:0] size, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat);
        int guard;
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        if (s3) req_valid3 = 1'b1; else req_valid1 = 1'b1;
        guard = 0;
        while (!(s3 ? req_ready3 : req_ready1) && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        @(posedge clk); #1;
        req_valid1 = 1'b0; req_valid3 = 1'b0;
        lat = 1;
        while (!(s3 ? rsp_valid3 : rsp_valid1) && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        rdata = s3 ? rsp_rdata3 : rsp_rdata1;
        err   = s3 ? rsp_err3 : rsp_err1;
        if (s3) rsp_ready3 = 1'b1; else rsp_ready1 = 1'b1;
        @(posedge clk); #1;
        rsp_ready1 = 1'b0; rsp_ready3 = 1'b0;
    endtask

    task automatic test_reset;
        reset1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (req_ready1 !== 1'b0) begin fails++; $display("FAIL reset_req_ready got %0b exp 0", req_ready1); end
        tests++; if (rsp_valid1 !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %0b exp 0", rsp_valid1); end
        tests++; if (rsp_err1 !== 1'b0) begin fails++; $display("FAIL reset_rsp_err got %0b exp 0", rsp_err1); end
        tests++; if (rsp_rdata1 !== 32'd0) begin fails++; $display("FAIL reset_rsp_rdata got %h exp 0", rsp_rdata1); end
        reset1 = 1'b1;
        @(posedge clk); #1;
        tests++; if (req_ready1 !== 1'b1) begin fails++; $display("FAIL reset_release_ready got %0b exp 1", req_ready1); end
    endtask

    task automatic test_word;
        logic [31:0] rd; logic er; int lat;
        do_txn(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, rd, er, lat);
        tests++; if (lat !== 2) begin fails++; $display("FAIL sw_latency got %0d exp 2", lat); end
        tests++; if (er !== 1'b0 || rd !== 32'd0) begin fails++; $display("FAIL sw_rsp got err=%0b rd=%h exp err=0 rd=0", er, rd); end
        do_txn(0, 0, 2'b10, 0, 32'h10, 32'h0, rd, er, lat);
        tests++; if (lat !== 2) begin fails++; $display("FAIL lw_latency got %0d exp 2", lat); end
        tests++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin fails++; $display("FAIL lw_data got %h err=%0b exp deadbeef err=0", rd, er); end
    endtask

    task automatic test_byte;
        logic [31:0] rd; logic er; int lat;
        do_txn(0, 1, 2'b10, 0, 32'h10, 32'h11223344, rd, er, lat);
        do_txn(0, 1, 2'b00, 0, 32'h13, 32'hABCDEF80, rd, er, lat);
        tests++; if (er !== 1'b0) begin fails++; $display("FAIL sb_err got %0b exp 0", er); end
        do_txn(0, 0, 2'b00, 0, 32'h13, 32'h0, rd, er, lat);
        tests++; if (rd !== 32'hFFFFFF80) begin fails++; $display("FAIL lb got %h exp ffffff80", rd); end
        do_txn(0, 0, 2'b00, 1, 32'h13, 32'h0, rd, er, lat);
        tests++; if (rd !== 32'h00000080) begin fails++; $display("FAIL lbu got %h exp 00000080", rd); end
        do_txn(0, 0, 2'b10, 0, 32'h10, 32'h0, rd, er, lat);
        tests++; if (rd !== 32'h80223344) begin fails++; $display("FAIL lw_after_sb got %h exp 80223344", rd); end
        do_txn(0, 0, 2'b00, 0, 32'h11, 32'h0, rd, er, lat);
        tests++; if (rd !== 32'h00000033) begin fails++; $display("FAIL lb_lane1 got %h exp 00000033", rd); end
    endtask

    task automatic test_half;
        logic [31:0] rd; logic er; int lat;
        do_txn(0, 1, 2'b10, 0, 32'h20, 32'hA5A5A5A5, rd, er, lat);
        do_txn(0, 1, 2'b01, 0, 32'h22, 32'h77778001, rd, er, lat);
        do_txn(0, 0, 2'b01, 0, 32'h22, 32'h0, rd, er, lat);
        tests++; if (rd !== 32'hFFFF8001) begin fails++; $display("FAIL lh got %h exp ffff8001", rd); end
        do_txn(0, 0, 2'b01, 1, 32'h22, 32'h0, rd, er, lat);
        tests++; if (rd !== 32'h00008001) begin fails++; $display("FAIL lhu got %h exp 00008001", rd); end
        do_txn(0, 1, 2'b01, 0, 32'h21, 32'h00001234, rd, er, lat);
        tests++; if (er !== 1'b1) begin fails++; $display("FAIL sh_misaligned_err got %0b exp 1", er); end
        do_txn(0, 0, 2'b10, 0, 32'h20, 32'h0, rd, er, lat);
        tests++; if (rd !== 32'h8001A5A5) begin fails++; $display("FAIL word20_unchanged got %h exp 8001a5a5", rd); end
    endtask

    task automatic test_errors;
        logic [31:0] rd; logic er; int lat;
        do_txn(0, 0, 2'b10, 0, 32'h1000, 32'h0, rd, er, lat);
        tests++; if (er !== 1'b1 || rd !== 32'd0) begin fails++; $display("FAIL lw_out_of_range got err=%0b rd=%h exp err=1 rd=0", er, rd); end
        do_txn(0, 0, 2'b11, 0, 32'h10, 32'h0, rd, er, lat);
        tests++; if (er !== 1'b1 || rd !== 32'd0) begin fails++; $display("FAIL size_rsvd got err=%0b rd=%h exp err=1 rd=0", er, rd); end
        do_txn(0, 0, 2'b10, 0, 32'h12, 32'h0, rd, er, lat);
        tests++; if (er !== 1'b1) begin fails++; $display("FAIL lw_misaligned got err=%0b exp 1", er); end
        do_txn(0, 1, 2'b10, 0, 32'hFFC, 32'hCAFEF00D, rd, er, lat);
        do_txn(0, 0, 2'b10, 0, 32'hFFC, 32'h0, rd, er, lat);
        tests++; if (er !== 1'b0 || rd !== 32'hCAFEF00D) begin fails++; $display("FAIL last_word got err=%0b rd=%h exp err=0 rd=cafef00d", er, rd); end
    endtask

    task automatic test_backpressure;
        int guard;
        req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h10;
        req_valid1 = 1'b1;
        @(posedge clk); #1;
        req_valid1 = 1'b0;
        guard = 0;
        while (!rsp_valid1 && guard < 20) begin @(posedge clk); #1; guard++; end
        for (int i = 0; i < 5; i++) begin
            tests++; if (rsp_valid1 !== 1'b1 || rsp_rdata1 !== 32'h80223344 || req_ready1 !== 1'b0) begin
                fails++; $display("FAIL hold_cycle%0d got v=%0b rd=%h rr=%0b exp v=1 rd=80223344 rr=0", i, rsp_valid1, rsp_rdata1, req_ready1);
            end
            @(posedge clk); #1;
        end
        rsp_ready1 = 1'b1;
        @(posedge clk); #1;
        rsp_ready1 = 1'b0;
        tests++; if (rsp_valid1 !== 1'b0 || req_ready1 !== 1'b1) begin fails++; $display("FAIL release_idle got v=%0b rr=%0b exp v=0 rr=1", rsp_valid1, req_ready1); end
    endtask

    task automatic test_back_to_back;
        int accepts = 0;
        req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h10;
        rsp_ready1 = 1'b1; req_valid1 = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (req_ready1) accepts++;
            @(posedge clk); #1;
        end
        req_valid1 = 1'b0; rsp_ready1 = 1'b0;
        tests++; if (accepts !== 3) begin fails++; $display("FAIL throughput_accepts got %0d exp 3", accepts); end
        tests++; if (req_ready1 !== 1'b1 || rsp_valid1 !== 1'b0) begin fails++; $display("FAIL throughput_drain got rr=%0b v=%0b exp rr=1 v=0", req_ready1, rsp_valid1); end
    endtask

    task automatic test_reset_in_wait;
        logic [31:0] rd; logic er; int lat;
        reset3 = 1'b0;
        repeat (2) @(posedge clk);
        #1; reset3 = 1'b1;
        @(posedge clk); #1;
        do_txn(1, 1, 2'b10, 0, 32'h30, 32'h11111111, rd, er, lat);
        tests++; if (lat !== 4) begin fails++; $display("FAIL ws3_latency got %0d exp 4", lat); end
        req_we = 1'b1; req_size = 2'b10; req_addr = 32'h30; req_wdata = 32'h55;
        req_valid3 = 1'b1;
        @(posedge clk); #1;
        req_valid3 = 1'b0;
        repeat (2) @(posedge clk);
        #1; reset3 = 1'b0;
        @(posedge clk); #1;
        tests++; if (req_ready3 !== 1'b0 || rsp_valid3 !== 1'b0 || rsp_err3 !== 1'b0 || rsp_rdata3 !== 32'd0) begin
            fails++; $display("FAIL reset_in_wait_outputs got rr=%0b v=%0b e=%0b rd=%h exp all 0", req_ready3, rsp_valid3, rsp_err3, rsp_rdata3);
        end
        repeat (3) @(posedge clk);
        #1; reset3 = 1'b1;
        @(posedge clk); #1;
        tests++; if (req_ready3 !== 1'b1 || rsp_valid3 !== 1'b0) begin fails++; $display("FAIL reset_in_wait_release got rr=%0b v=%0b exp rr=1 v=0", req_ready3, rsp_valid3); end
        do_txn(1, 0, 2'b10, 0, 32'h30, 32'h0, rd, er, lat);
        tests++; if (rd !== 32'h11111111 || er !== 1'b0) begin fails++; $display("FAIL aborted_store got %h err=%0b exp 11111111 err=0", rd, er); end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset;
        test_word;
        test_byte;
        test_half;
        test_errors;
        test_backpressure;
        test_back_to_back;
        test_reset_in_wait;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the single-cycle RISC-V core: the memory-side end of the core's load/store port. It accepts one load or store per valid/ready handshake, applies RV32I sub-word rules (byte/half/word, sign/zero extension, byte-lane write enables), models a configurable number of wait states, and returns a response on a separate valid/ready channel. It sits between the core's bus adapter and a word-organised on-chip RAM array that it owns.

## Interface
Parameters:
- DEPTH_WORDS, 1024: RAM depth in 32-bit words; legal word index is 0..DEPTH_WORDS-1.
- WAIT_STATES, 1: extra cycles between acceptance and commit; legal range 0..15.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  loads only: 1 = zero-extend (lbu/lhu), 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  32  load data, extended; 0 for stores and errors.
- rsp_err  out  1  misaligned, reserved-size or out-of-range request.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, capture we/size/unsigned/addr/wdata; go to WAIT if WAIT_STATES>0 (load counter with WAIT_STATES-1), else COMMIT directly into RESP.
- WAIT: req_ready=0; counter decrements each cycle; at counter==0, commit and go to RESP.
- Commit (single cycle, on the transition into RESP): evaluate error; if no error and store, write enabled byte lanes; if no error and load, register extended read data into rsp_rdata.
- Error: size==11; half with addr[0]!=0; word with addr[1:0]!=0; addr[31:2] >= DEPTH_WORDS. Error → no RAM write, rsp_rdata=0, rsp_err=1.
- Byte lanes: byte uses lane addr[1:0]; half uses lanes {addr[1],0}+{1,0}; word uses all four. Store replicates wdata into selected lanes; untouched lanes unchanged.
- Load extension: byte sign bit = lane bit 7; half sign bit = bit 15; word unchanged.
- RESP: rsp_valid=1, outputs held stable until rsp_valid&&rsp_ready, then IDLE. No new request accepted in the same cycle as the response handshake.
- reset low: state→IDLE, counter→0, rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=0 during the reset cycle and 1 on the first cycle after release. RAM contents are not cleared.
- Reset during WAIT aborts the transaction: no write occurs. Reset during RESP drops the response; the write already committed stays.

## Timing
- Request accepted at edge N → rsp_valid high from cycle N+1+WAIT_STATES.
- Throughput: one transaction per 2+WAIT_STATES cycles with rsp_ready held high.
- Store visible to a load whose commit is strictly after the store's commit (always true given one outstanding transaction).
- req_ready, rsp_valid, rsp_rdata, rsp_err are registered; no combinational path from req_* or rsp_ready to any output.

## Structure
- Package riscv_mem_pkg: mem_size_t enum (SIZE_B, SIZE_H, SIZE_W, SIZE_RSVD), dmem_state_t enum (IDLE, WAIT, RESP), and the misalign-check function.
- One sub-module dmem_lane_align: combinational; store byte-enable/replication and load lane extraction plus extension from size, unsigned, addr[1:0].
- RAM as a word array with per-byte write enables in the top module.

## Test plan
- WAIT_STATES=1: sw 0xDEADBEEF at 0x10, then lw 0x10 → rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 2 cycles after each acceptance.
- sb 0x80 at 0x13 over word 0x11223344, then lb 0x13 → 0xFFFFFF80, lbu 0x13 → 0x00000080, lw 0x10 → 0x80223344.
- sh 0x8001 at 0x22, lh 0x22 → 0xFFFF8001, lhu → 0x00008001; sh at 0x21 → rsp_err=1, word 0x20 unchanged.
- lw at byte address 4*DEPTH_WORDS → rsp_err=1, rsp_rdata=0; size=11 → rsp_err=1.
- rsp_ready held low 5 cycles in RESP → rsp_valid/rsp_rdata stable, req_ready=0 throughout; release → IDLE next cycle.
- WAIT_STATES=3: assert reset low during WAIT of sw 0x55 at 0x30 → no write (later lw 0x30 returns prior value), all outputs at reset values.
